ram_access_arb: RTL and testbench
=================================

RAM_ACCESS_ARB -- requirements
Module: ram_access_arb

Interface
REQ-001 Parameter ADDR_W, default 8, RAM address width.
REQ-002 Parameter DATA_W, default 4, RAM data width.
REQ-003 Parameter DEPTH, default 145 (8'h91), number of readable words per full burst.
REQ-004 clock  in  1  single clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 wr_req  in  1  write requester asks for one write this cycle.
REQ-007 wr_addr  in  ADDR_W  write address, sampled when wr_gnt=1.
REQ-008 wr_data  in  DATA_W  write data, sampled when wr_gnt=1.
REQ-009 wr_gnt  out  1  combinational; write accepted this cycle.
REQ-010 rd_start  in  1  one-cycle pulse; starts a sequential read burst from address 0.
REQ-011 rd_len  in  ADDR_W  burst length, sampled with rd_start.
REQ-012 rd_busy  out  1  burst in progress (any state except IDLE).
REQ-013 rd_valid  out  1  rd_data holds a burst word this cycle.
REQ-014 rd_data  out  DATA_W  burst read data.
REQ-015 rd_done  out  1  one-cycle pulse; burst complete.
REQ-016 ram_address  out  ADDR_W  registered RAM address.
REQ-017 ram_data  out  DATA_W  registered RAM write data.
REQ-018 ram_wren  out  1  registered RAM write enable.
REQ-019 ram_q  in  DATA_W  RAM read data, valid 1 cycle after ram_address is presented.

Function
REQ-020 States: IDLE, BURST, DRAIN; IDLE->BURST on rd_start, BURST->DRAIN after last read is issued, DRAIN->IDLE after 2 cycles with rd_done pulsed on the 2nd.
REQ-021 In IDLE, wr_gnt=wr_req.
REQ-022 Effective length L = min(rd_len, DEPTH); rd_len=0 skips BURST and goes to DRAIN, so rd_done comes 2 cycles after rd_start with no rd_valid.
REQ-023 In BURST, each cycle either one write or one read is issued, never both; the read pointer starts at 0 and increments only on issued reads.
REQ-024 A read issued in cycle t drives ram_address at t+1; rd_valid=1 and rd_data=ram_q in cycle t+2; exactly L rd_valid pulses per burst, addresses 0..L-1 in order.
REQ-025 Without round-robin (REQ-031), write has fixed priority: the read stalls in any cycle with wr_req=1.
REQ-026 Issued write: ram_wren=1, ram_address=wr_addr, ram_data=wr_data one cycle after wr_gnt; otherwise ram_wren=0.
REQ-027 rd_start while rd_busy=1 is ignored; rd_len is not resampled.
REQ-028 The read pointer is ADDR_W wide and never wraps, because L<=DEPTH<=2^ADDR_W.
REQ-029 A write to an address not yet read in the current burst is visible to that burst's later read.

Reset
REQ-030 On reset: state=IDLE, read pointer=0, ram_address=0, ram_data=0, ram_wren=0, rd_valid=0, rd_data=0, rd_done=0, wr_gnt=0; this aborts any burst in flight and drops its outstanding rd_valid.

Configuration
REQ-031 Macro RAM_ARB_RR_EN: when defined, if both sides contend in BURST, grant alternates, with the side not granted in the last contended cycle winning next and write winning the first contention of each burst; when undefined, REQ-025 applies.

Structure
REQ-032 Package ram_arb_pkg holds the state enum and the DEPTH, ADDR_W and DATA_W defaults.
REQ-033 Sub-module ram_arb_rr (2-way grant logic, including the RAM_ARB_RR_EN variant) is instantiated once.

Verification
REQ-034 rd_start, rd_len=4, no writes -> rd_valid for 4 cycles starting 2 cycles after the first issue, data = contents of 0..3, rd_done 2 cycles after the last issue.
REQ-035 rd_len=200 -> exactly 145 rd_valid pulses (addresses 0..144), then rd_done.
REQ-036 wr_req held high during a rd_len=8 burst, macro undefined -> no reads until wr_req drops; macro defined -> writes and reads alternate, and the burst takes 16 cycles of issue.
REQ-037 Write 4'hA to address 5 in cycle 2 of a burst -> the burst's 6th word reads 4'hA.
REQ-038 reset asserted mid-burst -> next cycle rd_busy=0, rd_valid=0, ram_wren=0, and a new rd_start is accepted immediately.
REQ-039 rd_len=0 -> rd_done 2 cycles later and zero rd_valid; a second rd_start during a busy burst causes no change.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and default geometry for the RAM access arbiter.
package ram_arb_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 4;
    localparam int DEF_DEPTH  = 145;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Burst length clipped to the readable depth.
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned depth);
        return (len < depth) ? len : depth;
    endfunction

endpackage

// File: rtl/ram_access_arb_if.sv
// Bus bundle between the write requester, burst reader and RAM port of ram_access_arb.
interface ram_access_arb_if
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_gnt;

    logic              rd_start;
    logic [ADDR_W-1:0] rd_len;
    logic              rd_busy;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_done;

    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_start, rd_len, ram_q,
        output wr_gnt, rd_busy, rd_valid, rd_data, rd_done,
               ram_address, ram_data, ram_wren
    );

    modport master (
        output wr_req, wr_addr, wr_data, rd_start, rd_len, ram_q,
        input  wr_gnt, rd_busy, rd_valid, rd_data, rd_done,
               ram_address, ram_data, ram_wren
    );

endinterface

// File: rtl/ram_arb_rr.sv
// Two-way write/read grant. RAM_ARB_RR_EN selects alternating grant under
// contention; otherwise write always wins.
module ram_arb_rr
    import ram_arb_pkg::*;
(
`ifdef RAM_ARB_RR_EN
    input  logic clock,
    input  logic reset,
`endif
    input  logic wr_req_i,
    input  logic rd_req_i,
    output logic wr_gnt_o,
    output logic rd_gnt_o
);

`ifdef RAM_ARB_RR_EN
    logic rd_turn_q, rd_turn_d;
    logic contend;

    assign contend = wr_req_i & rd_req_i;

    // Cleared outside a burst so write takes the first contention of each burst.
    always_comb begin
        rd_turn_d = rd_turn_q;
        if (!rd_req_i) begin
            rd_turn_d = 1'b0;
        end else if (contend) begin
            rd_turn_d = ~rd_turn_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_turn_q <= 1'b0;
        end else begin
            rd_turn_q <= rd_turn_d;
        end
    end

    assign wr_gnt_o = wr_req_i & ~(contend & rd_turn_q);
    assign rd_gnt_o = rd_req_i & ~(contend & ~rd_turn_q);
`else
    assign wr_gnt_o = wr_req_i;
    assign rd_gnt_o = rd_req_i & ~wr_req_i;
`endif

endmodule

// File: rtl/ram_access_arb.sv
// Shares one single-port RAM between a write requester and a sequential burst
// reader. Define RAM_ARB_RR_EN for alternating grant under contention.
module ram_access_arb
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic            clock,
    input  logic            reset,
    ram_access_arb_if.slave bus
);

    localparam int LEN_W = ADDR_W + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              drain_q, drain_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wren_q, wren_d;
    logic              issue_q, issue_d;
    logic              valid_q;

    logic rd_req;
    logic arb_wr_gnt;
    logic arb_rd_gnt;
    logic wr_fire;

    assign rd_req = (state_q == ST_BURST);

    ram_arb_rr u_arb (
`ifdef RAM_ARB_RR_EN
        .clock    (clock),
        .reset    (reset),
`endif
        .wr_req_i (bus.wr_req),
        .rd_req_i (rd_req),
        .wr_gnt_o (arb_wr_gnt),
        .rd_gnt_o (arb_rd_gnt)
    );

    assign wr_fire = arb_wr_gnt & ~reset;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        drain_d = (state_q == ST_DRAIN) && !drain_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wren_d  = 1'b0;
        issue_d = 1'b0;

        if (wr_fire) begin
            addr_d = bus.wr_addr;
            data_d = bus.wr_data;
            wren_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                ptr_d = '0;
                if (bus.rd_start) begin
                    len_d   = LEN_W'(eff_len(32'(bus.rd_len), 32'(DEPTH)));
                    state_d = (bus.rd_len == '0) ? ST_DRAIN : ST_BURST;
                end
            end
            ST_BURST: begin
                if (arb_rd_gnt) begin
                    issue_d = 1'b1;
                    addr_d  = ptr_q;
                    ptr_d   = ptr_q + ADDR_W'(1);
                    if (({1'b0, ptr_q} + LEN_W'(1)) == len_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Two cycles covering the RAM read latency of the last word.
                if (drain_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            len_q   <= '0;
            drain_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            wren_q  <= 1'b0;
            issue_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            drain_q <= drain_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wren_q  <= wren_d;
            issue_q <= issue_d;
            valid_q <= issue_q;
        end
    end

    assign bus.wr_gnt      = wr_fire;
    assign bus.rd_busy     = (state_q != ST_IDLE);
    assign bus.rd_valid    = valid_q;
    assign bus.rd_data     = valid_q ? bus.ram_q : '0;
    assign bus.rd_done     = (state_q == ST_DRAIN) && drain_q;
    assign bus.ram_address = addr_q;
    assign bus.ram_data    = data_q;
    assign bus.ram_wren    = wren_q;

endmodule

// File: tb/tb_ram_access_arb.sv
// Bench for ram_access_arb: RAM model, transaction-level reference model and
// directed bursts. Build with +define+RAM_ARB_RR_EN for the alternating variant.
module tb_ram_access_arb;
    import ram_arb_pkg::*;

    localparam int AW  = 8;
    localparam int DW  = 4;
    localparam int DEP = 145;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ram_access_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_access_arb #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_val(input int i);
        return DW'((i * 3 + 1) % 16);
    endfunction

    // RAM: registered read, contents restored to the known pattern on reset
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] ram_q_r;
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= init_val(i);
        end else if (bus.ram_wren) begin
            mem[bus.ram_address] <= bus.ram_data;
        end
        ram_q_r <= mem[bus.ram_address];
    end
    assign bus.ram_q = ram_q_r;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: per-cycle transaction view of the arbiter
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    int            m_left = 0, m_next = 0, m_done_cyc = -1;
    int            m_wren_cyc = -1, m_raddr_cyc = -1;
    logic [AW-1:0] m_waddr, m_raddr;
    logic [DW-1:0] m_wdata;
    bit            m_rd_turn = 1'b0;
    int            vq_cyc[$];
    logic [DW-1:0] vq_dat[$];

    always @(negedge clock) begin : model
        bit busy, in_burst, wr_win, rd_iss, e_valid;
        int len;
        if (reset) begin
            chk("wr_gnt_in_reset", bus.wr_gnt, 0);
            m_left = 0; m_done_cyc = -1; m_wren_cyc = -1; m_raddr_cyc = -1; m_rd_turn = 1'b0;
            vq_cyc.delete(); vq_dat.delete();
            for (int i = 0; i < (1 << AW); i++) shadow[i] = init_val(i);
        end else begin
            in_burst = (m_left > 0);
            busy     = in_burst || (m_done_cyc >= cyc);
            wr_win   = bus.wr_req;
            if (in_burst && bus.wr_req) begin
`ifdef RAM_ARB_RR_EN
                wr_win    = !m_rd_turn;
                m_rd_turn = !m_rd_turn;
`else
                wr_win = 1'b1;
`endif
            end
            rd_iss  = in_burst && !wr_win;
            e_valid = (vq_cyc.size() > 0) && (vq_cyc[0] == cyc);

            chk("rd_busy", bus.rd_busy, busy);
            chk("wr_gnt", bus.wr_gnt, wr_win);
            chk("rd_valid", bus.rd_valid, e_valid);
            if (e_valid) begin
                chk("rd_data", bus.rd_data, vq_dat[0]);
                void'(vq_cyc.pop_front());
                void'(vq_dat.pop_front());
            end
            chk("rd_done", bus.rd_done, m_done_cyc == cyc);
            chk("ram_wren", bus.ram_wren, m_wren_cyc == cyc);
            if (m_wren_cyc == cyc) begin
                chk("ram_wr_addr", bus.ram_address, m_waddr);
                chk("ram_wr_data", bus.ram_data, m_wdata);
            end
            if (m_raddr_cyc == cyc) chk("ram_rd_addr", bus.ram_address, m_raddr);

            if (wr_win) begin
                shadow[bus.wr_addr] = bus.wr_data;
                m_wren_cyc = cyc + 1; m_waddr = bus.wr_addr; m_wdata = bus.wr_data;
            end
            if (rd_iss) begin
                vq_cyc.push_back(cyc + 2);
                vq_dat.push_back(shadow[m_next]);
                m_raddr_cyc = cyc + 1; m_raddr = AW'(m_next);
                m_next++; m_left--;
                if (m_left == 0) m_done_cyc = cyc + 2;
            end
            if (!busy && bus.rd_start) begin
                len = (int'(bus.rd_len) < DEP) ? int'(bus.rd_len) : DEP;
                if (len == 0) m_done_cyc = cyc + 2;
                else begin
                    m_left = len; m_next = 0; m_rd_turn = 1'b0;
                end
            end
        end
    end

    // Burst monitor for the directed literal checks
    int            mon_vcnt = 0, mon_first = -1, mon_done = -1;
    logic [DW-1:0] mon_data[$];
    always @(negedge clock) begin
        if (bus.rd_valid) begin
            mon_vcnt++;
            if (mon_first < 0) mon_first = cyc;
            mon_data.push_back(bus.rd_data);
        end
        if (bus.rd_done && mon_done < 0) mon_done = cyc;
    end

    task automatic mon_clear();
        mon_vcnt = 0; mon_first = -1; mon_done = -1; mon_data.delete();
    endtask

    function automatic int word(input int i);
        return (i < mon_data.size()) ? int'(mon_data[i]) : -1;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_wr(input logic [63:0] wpat, input int k, input int abase, input int dbase);
        bus.wr_req  = (k < 64) ? wpat[k] : 1'b0;
        bus.wr_addr = AW'(abase + k);
        bus.wr_data = DW'(dbase + k);
    endtask

    int start_cyc;

    task automatic wait_done(input int budget);
        int k = 0;
        while (mon_done < 0 && k < budget) begin
            tick();
            k++;
        end
        chk("burst_timeout", mon_done >= 0, 1);
    endtask

    // wpat bit k drives wr_req in cycle start+k; restart_off re-pulses rd_start
    task automatic run_burst(input int len, input logic [63:0] wpat, input int abase,
                             input int dbase, input int restart_off);
        int k = 0;
        mon_clear();
        bus.rd_start = 1'b1;
        bus.rd_len   = AW'(len);
        drive_wr(wpat, 0, abase, dbase);
        start_cyc = cyc;
        while (mon_done < 0 && k < 400) begin
            tick();
            k++;
            bus.rd_start = (k == restart_off);
            if (k == restart_off) bus.rd_len = 8'd9;
            drive_wr(wpat, k, abase, dbase);
        end
        chk("burst_timeout", mon_done >= 0, 1);
        bus.wr_req   = 1'b0;
        bus.rd_start = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        bus.wr_req = 1'b1; bus.wr_addr = 8'd9; bus.wr_data = 4'd3;
        bus.rd_start = 1'b0; bus.rd_len = '0;
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_wr_gnt", bus.wr_gnt, 0);
        reset = 1'b0;
        bus.wr_req = 1'b0;
        chk("rst_busy", bus.rd_busy, 0);
        chk("rst_valid", bus.rd_valid, 0);
        chk("rst_done", bus.rd_done, 0);
        chk("rst_wren", bus.ram_wren, 0);
        chk("rst_addr", bus.ram_address, 0);
        chk("rst_data", bus.ram_data, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        tick();

        // Plain burst of four words
        run_burst(4, 64'h0, 0, 0, -1);
        $display("burst len=4: valids=%0d first=+%0d done=+%0d", mon_vcnt, mon_first - start_cyc, mon_done - start_cyc);
        chk("len4_count", mon_vcnt, 4);
        chk("len4_first", mon_first - start_cyc, 3);
        chk("len4_done", mon_done - start_cyc, 6);
        chk("len4_w0", word(0), 1);
        chk("len4_w1", word(1), 4);
        chk("len4_w2", word(2), 7);
        chk("len4_w3", word(3), 10);

        // Length above DEPTH clips to 145 words
        run_burst(200, 64'h0, 0, 0, -1);
        $display("burst len=200: valids=%0d done=+%0d", mon_vcnt, mon_done - start_cyc);
        chk("clip_count", mon_vcnt, 145);
        chk("clip_done", mon_done - start_cyc, 147);
        chk("clip_w100", word(100), 13);
        chk("clip_w144", word(144), 1);

        // Writer held high across a burst of eight
`ifdef RAM_ARB_RR_EN
        run_burst(8, 64'h7FFFE, 200, 0, -1);
        chk("hold_first", mon_first - start_cyc, 4);
        chk("hold_done", mon_done - start_cyc, 18);
`else
        run_burst(8, 64'h7FE, 200, 0, -1);
        chk("hold_first", mon_first - start_cyc, 13);
        chk("hold_done", mon_done - start_cyc, 20);
`endif
        $display("burst len=8 with writer held: valids=%0d first=+%0d done=+%0d", mon_vcnt, mon_first - start_cyc, mon_done - start_cyc);
        chk("hold_count", mon_vcnt, 8);
        chk("hold_w7", word(7), 6);

        // Write 0xA to address 5 in burst cycle 2
        run_burst(8, 64'h4, 3, 8, -1);
        $display("burst len=8 with write a5<=A: valids=%0d w5=%0d done=+%0d", mon_vcnt, word(5), mon_done - start_cyc);
        chk("wnew_count", mon_vcnt, 8);
        chk("wnew_w4", word(4), 13);
        chk("wnew_w5", word(5), 10);
        chk("wnew_done", mon_done - start_cyc, 11);

        // Reset in the middle of a burst, then immediate restart
        mon_clear();
        bus.rd_start = 1'b1; bus.rd_len = 8'd50;
        tick();
        bus.rd_start = 1'b0;
        repeat (9) tick();
        reset = 1'b1; bus.wr_req = 1'b1; bus.wr_addr = 8'd9; bus.wr_data = 4'd3;
        tick();
        reset = 1'b0; bus.wr_req = 1'b0;
        chk("abort_busy", bus.rd_busy, 0);
        chk("abort_valid", bus.rd_valid, 0);
        chk("abort_wren", bus.ram_wren, 0);
        mon_clear();
        bus.rd_start = 1'b1; bus.rd_len = 8'd3;
        start_cyc = cyc;
        tick();
        bus.rd_start = 1'b0;
        chk("restart_busy", bus.rd_busy, 1);
        wait_done(50);
        $display("restart len=3 after reset: valids=%0d done=+%0d", mon_vcnt, mon_done - start_cyc);
        chk("restart_count", mon_vcnt, 3);
        chk("restart_done", mon_done - start_cyc, 5);
        chk("restart_w2", word(2), 7);
        tick();
        tick();

        // Zero length, then a second rd_start during a busy burst
        run_burst(0, 64'h0, 0, 0, -1);
        $display("burst len=0: valids=%0d done=+%0d", mon_vcnt, mon_done - start_cyc);
        chk("zero_count", mon_vcnt, 0);
        chk("zero_done", mon_done - start_cyc, 2);
        run_burst(4, 64'h0, 0, 0, 2);
        $display("burst len=4 with extra start: valids=%0d done=+%0d", mon_vcnt, mon_done - start_cyc);
        chk("extra_count", mon_vcnt, 4);
        chk("extra_done", mon_done - start_cyc, 6);

        // Mixed write pattern overlapping the burst's own addresses
        run_burst(12, 64'h36D5A6, 2, 5, -1);
        $display("burst len=12 mixed writes: valids=%0d done=+%0d", mon_vcnt, mon_done - start_cyc);
        chk("mixed_count", mon_vcnt, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
